// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } scan_res_e;

    typedef enum logic {
        DB_RELEASED,
        DB_PRESSED
    } db_state_e;

    // Debounce candidate: the last non-MULTI scan result.
    typedef struct packed {
        scan_res_e  kind;
        logic [3:0] code;
    } scan_cand_t;

    // Pmod KYPD layout, indexed {row, col}.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pins plus the decoded key outputs; master is the scanner side.
interface keypad_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input row, output col, key_code, key_valid, key_held);
    modport slave  (output row, input col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer; resets to all-ones so idle-high rows read as released.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages shift on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/keypad_scan.sv
// Column sequencer, per-scan accumulator and debounce FSM for a 4x4 keypad.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic           clk,
    input  logic           rst,
    keypad_scan_if.master  kp
);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

    logic [3:0]        row_sync;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        cidx_q, cidx_d;
    logic [3:0]        col_q, col_d;
    logic [1:0]        hits_q, hits_d;
    logic [3:0]        hit_idx_q, hit_idx_d;
    scan_cand_t        cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    db_state_e         state_q, state_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;

    logic       sample, scan_end;
    logic [2:0] col_lows, tot_lows;
    logic [1:0] col_row;
    logic [1:0] hits_new;
    logic [3:0] idx_new;
    scan_res_e  res;
    logic [3:0] res_code;
    logic       same, stable;

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (kp.row),
        .q_o (row_sync)
    );

    assign sample   = (div_q == DIV_LAST);
    assign scan_end = sample && (cidx_q == 2'd3);

    // Lows seen in the current column, folded into a saturating per-scan hit count.
    always_comb begin
        col_lows = 3'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                col_lows = col_lows + 3'd1;
                col_row  = 2'(r);
            end
        end
        tot_lows = {1'b0, hits_q} + col_lows;
        hits_new = (tot_lows >= 3'd2) ? 2'd2 : tot_lows[1:0];
        idx_new  = (hits_q == 2'd0 && col_lows == 3'd1) ? {col_row, cidx_q} : hit_idx_q;
        res      = (hits_new == 2'd0) ? RES_NONE : (hits_new == 2'd1) ? RES_SINGLE : RES_MULTI;
        res_code = KEY_MAP[idx_new];
    end

    always_comb begin
        div_d     = sample ? '0 : div_q + DIV_ONE;
        cidx_d    = sample ? cidx_q + 2'd1 : cidx_q;
        col_d     = ~(4'b0001 << cidx_d);
        hits_d    = hits_q;
        hit_idx_d = hit_idx_q;
        if (sample) begin
            hits_d    = scan_end ? 2'd0 : hits_new;
            hit_idx_d = scan_end ? 4'd0 : idx_new;
        end
    end

    // NOTE: every variable gets its default before any branch, so no latches are inferred.
    always_comb begin
        cand_d      = cand_q;
        stab_d      = stab_q;
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        same        = 1'b0;
        stable      = 1'b0;

        // MULTI scans carry no information and leave the debounce untouched.
        if (scan_end && res != RES_MULTI) begin
            same = (res == cand_q.kind) && (res == RES_NONE || res_code == cand_q.code);
            if (same) begin
                stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + STAB_ONE;
            end else begin
                stab_d      = STAB_ONE;
                cand_d.kind = res;
                cand_d.code = (res == RES_SINGLE) ? res_code : 4'h0;
            end
            stable = (stab_d == STAB_MAX);

            unique case (state_q)
                DB_RELEASED: begin
                    if (stable && cand_d.kind == RES_SINGLE) begin
                        state_d     = DB_PRESSED;
                        key_code_d  = cand_d.code;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end
                end
                DB_PRESSED: begin
                    if (stable && cand_d.kind == RES_NONE) begin
                        state_d    = DB_RELEASED;
                        key_held_d = 1'b0;
                    end else if (stable && cand_d.code != key_code_q) begin
                        key_code_d  = cand_d.code;
                        key_valid_d = 1'b1;
                    end
                end
                default: state_d = DB_RELEASED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            cidx_q      <= 2'd0;
            col_q       <= 4'b1110;
            hits_q      <= 2'd0;
            hit_idx_q   <= 4'd0;
            cand_q      <= '{kind: RES_NONE, code: 4'h0};
            stab_q      <= '0;
            state_q     <= DB_RELEASED;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            cidx_q      <= cidx_d;
            col_q       <= col_d;
            hits_q      <= hits_d;
            hit_idx_q   <= hit_idx_d;
            cand_q      <= cand_d;
            stab_q      <= stab_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.col       = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 matrix keypad (Pmod KYPD layout) and converts one key press into a 4-bit hex code with a single-cycle valid strobe. It is the input-side counterpart of the seven-segment driver: the driver turns a 4-bit value into segment and anode drive, and this block turns column drive and row sense back into a 4-bit value. Its outputs feed the same 4-bit data path that the switches feed today.

## Interface
- SCAN_DIV, 100000: clock cycles each column is driven (1 ms at 100 MHz); legal range is ≥ 4.
- DEBOUNCE_SCANS, 4: number of consecutive identical full-scan results needed to accept a change; legal range is ≥ 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- row  in  4  keypad rows, active-low (pulled up off-chip), asynchronous to clk.
- col  out  4  keypad column drive, active-low one-hot; col[c]=0 drives column c.
- key_code  out  4  hex code of the last accepted key.
- key_valid  out  1  one-cycle pulse when a new press is accepted.
- key_held  out  1  high while the accepted key is debounced-pressed.

## Operation
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- `row` passes through a 2-FF synchronizer before any use.
- Column counter `cidx` (0..3):
  - Each column is driven for SCAN_DIV cycles: `col = ~(1<<cidx)`.
  - The synchronized rows are sampled on the last dwell cycle (dwell count = SCAN_DIV-1).
  - After that sample, `cidx` increments and wraps 3→0.
- A scan spans 4 columns. The scan result is classified as:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one (row, col) low across the scan.
  - MULTI: two or more lows.
- MULTI is treated as "no new information". It does not reset the stability count and it does not change the debounced state.
- Stability counter `stab`:
  - Compares each NONE/SINGLE scan result with the previous one.
  - Equal → `stab` increments, saturating at DEBOUNCE_SCANS.
  - Different → `stab` = 1 and the candidate is updated.
- Debounce FSM:
  - RELEASED → PRESSED when the candidate is SINGLE(k) and `stab` reaches DEBOUNCE_SCANS. Actions: `key_code` ← k, `key_valid` pulses, `key_held` ← 1.
  - PRESSED → RELEASED when the candidate is NONE and `stab` reaches DEBOUNCE_SCANS. Action: `key_held` ← 0. `key_code` keeps its value.
  - PRESSED with a stable SINGLE(j), j ≠ current code (roll-over without release): `key_code` ← j, `key_valid` pulses, and the FSM stays in PRESSED.
  - PRESSED with stable SINGLE of the same code: no action. Holding a key never re-fires.
- Releasing and then pressing the same key again produces a new pulse.

## Timing
- Reset values:
  - `col` = 4'b1110, `cidx` = 0, dwell count = 0.
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0.
  - FSM = RELEASED, `stab` = 0, candidate = NONE.
- A reset asserted mid-scan or mid-debounce overrides everything on the next edge. The scan restarts at column 0. No `key_valid` is emitted during or on exit from reset.
- Row sense latency is 2 cycles (synchronizer). With SCAN_DIV ≥ 4, the sample sees the rows settled for the currently driven column.
- Scan period is 4·SCAN_DIV cycles. Scan evaluation happens at the edge where `cidx` wraps 3→0.
- `key_valid`, `key_code` and `key_held` update on that same edge. `key_valid` is high for exactly 1 cycle.
- Press-to-`key_valid` latency, for a press held steady from before a scan start: DEBOUNCE_SCANS scan periods. Worst case is (DEBOUNCE_SCANS+1)·4·SCAN_DIV + 2 cycles.
- Every output is registered; there is no combinational path from `row` to any output.

## Structure
- Package `keypad_pkg`:
  - key-map constant (16 × 4-bit, indexed {row,col});
  - scan-result enum: NONE / SINGLE / MULTI;
  - debounce-state enum: RELEASED / PRESSED.
- One sub-module, `sync2`: a 2-FF synchronizer parameterized by width (4 here), reset to all-ones (all rows idle-high).
- Column sequencer, scan accumulator and debounce FSM live in `keypad_scan`.

## Test plan
The bench uses SCAN_DIV=4 and DEBOUNCE_SCANS=2. The keypad model pulls row r low while the pressed key's column is driven low.
- Reset, then no keys for 10 scans → `col` cycles 1110, 1101, 1011, 0111 at 4 cycles each; `key_valid` never fires; `key_held` = 0.
- Hold key at (r1,c2) → exactly one `key_valid` pulse, with `key_code` = 4'h6 and `key_held` = 1, within 3 scan periods + 2 cycles; no further pulses over 20 scans of holding.
- Release, then press (r3,c1) → `key_held` falls after 2 NONE scans; then `key_code` = 4'hF with one pulse; repeat the same press → a second pulse.
- Bounce: toggle (r0,c0) every scan for 6 scans, then hold steady → no pulse during toggling; one pulse with `key_code` = 4'h1 after 2 stable scans.
- Press (r0,c3) and (r2,c0) simultaneously after (r0,c3) was accepted → no pulse while both are held; `key_code` stays 4'hA; releasing (r0,c3) leaves SINGLE 4'h7 → pulse with `key_code` = 4'h7 without `key_held` dropping.
- Assert `rst` for 1 cycle between the first and second qualifying scans of a press → no pulse from the interrupted sequence; `col` = 1110 immediately after reset; a fresh pulse arrives 2 full scans later.
